// File: rtl/controle_venda.sv
// Purpose : sale controller behind the coin adder; checks credit, releases the product, pays change coin-by-coin, then clears the adder.
// Latency : libera_produto pulses 2 cycles after the edge that samples confirma; saldo_insuf pulses 1 cycle after that edge.
// Backpressure: troco_valido/troco_moeda hold until troco_ack; limpa_soma holds until soma==0 is sampled.
//
// Ports:
//   clock, reset_n      rising-edge clock, asynchronous active-low reset
//   on_off              machine enable, low forces idle on the next edge
//   soma, valorultrapassou  credit and overflow flag from the coin adder
//   produto, confirma, cancela  product selection and buttons (sampled only when idle)
//   troco_ack           change dispenser accepted the offered coin
//   libera_produto      one-cycle release pulse
//   troco_valido, troco_moeda  coin offer (00=1, 01=2, 10=5, 11=10)
//   limpa_soma          clear request to the coin adder
//   saldo_insuf         one-cycle insufficient-credit pulse
//   ocupado             high whenever the controller is not idle
module controle_venda #(
    parameter int PRECO0 = 4,
    parameter int PRECO1 = 6,
    parameter int PRECO2 = 8,
    parameter int PRECO3 = 10
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       on_off,
    input  logic [4:0] soma,
    input  logic       valorultrapassou,
    input  logic [1:0] produto,
    input  logic       confirma,
    input  logic       cancela,
    input  logic       troco_ack,
    output logic       libera_produto,
    output logic       troco_valido,
    output logic [1:0] troco_moeda,
    output logic       limpa_soma,
    output logic       saldo_insuf,
    output logic       ocupado
);

    typedef enum logic [2:0] {
        OCIOSO,
        VERIFICA,
        LIBERA,
        TROCO,
        LIMPA
    } estado_t;

    estado_t    estado;
    logic [4:0] credito;
    logic [4:0] preco;
    logic [4:0] restante;

    function automatic logic [4:0] preco_de(input logic [1:0] p);
        case (p)
            2'd0:    preco_de = 5'(PRECO0);
            2'd1:    preco_de = 5'(PRECO1);
            2'd2:    preco_de = 5'(PRECO2);
            default: preco_de = 5'(PRECO3);
        endcase
    endfunction

    // Largest coin not exceeding the remaining change.
    function automatic logic [1:0] moeda_gulosa(input logic [4:0] v);
        if (v >= 5'd10)     moeda_gulosa = 2'b11;
        else if (v >= 5'd5) moeda_gulosa = 2'b10;
        else if (v >= 5'd2) moeda_gulosa = 2'b01;
        else                moeda_gulosa = 2'b00;
    endfunction

    function automatic logic [4:0] valor_moeda(input logic [1:0] c);
        case (c)
            2'b00:   valor_moeda = 5'd1;
            2'b01:   valor_moeda = 5'd2;
            2'b10:   valor_moeda = 5'd5;
            default: valor_moeda = 5'd10;
        endcase
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado         <= OCIOSO;
            credito        <= 5'd0;
            preco          <= 5'd0;
            restante       <= 5'd0;
            libera_produto <= 1'b0;
            troco_valido   <= 1'b0;
            troco_moeda    <= 2'b00;
            limpa_soma     <= 1'b0;
            saldo_insuf    <= 1'b0;
            ocupado        <= 1'b0;
        end else begin
            // Pulse outputs default low every cycle.
            libera_produto <= 1'b0;
            saldo_insuf    <= 1'b0;
            if (!on_off) begin
                // Power-off abandons any pending coin and change balance.
                estado       <= OCIOSO;
                restante     <= 5'd0;
                troco_valido <= 1'b0;
                troco_moeda  <= 2'b00;
                limpa_soma   <= 1'b0;
                ocupado      <= 1'b0;
            end else begin
                case (estado)
                    OCIOSO: begin
                        // Refund has priority over purchase; a refund with no
                        // credit is a no-op and also suppresses the purchase.
                        if (cancela || valorultrapassou) begin
                            if (soma != 5'd0) begin
                                restante <= soma;
                                estado   <= TROCO;
                                ocupado  <= 1'b1;
                            end
                        end else if (confirma) begin
                            credito <= soma;
                            preco   <= preco_de(produto);
                            estado  <= VERIFICA;
                            ocupado <= 1'b1;
                        end
                    end
                    VERIFICA: begin
                        if (credito >= preco) begin
                            restante <= credito - preco;
                            estado   <= LIBERA;
                        end else begin
                            saldo_insuf <= 1'b1;
                            estado      <= OCIOSO;
                            ocupado     <= 1'b0;
                        end
                    end
                    LIBERA: begin
                        libera_produto <= 1'b1;
                        estado         <= TROCO;
                    end
                    TROCO: begin
                        if (troco_valido) begin
                            // Coin held stable until accepted; after an accept
                            // the offer drops for one cycle before the next.
                            if (troco_ack) begin
                                restante     <= restante - valor_moeda(troco_moeda);
                                troco_valido <= 1'b0;
                                troco_moeda  <= 2'b00;
                            end
                        end else if (restante == 5'd0) begin
                            estado     <= LIMPA;
                            limpa_soma <= 1'b1;
                        end else begin
                            troco_valido <= 1'b1;
                            troco_moeda  <= moeda_gulosa(restante);
                        end
                    end
                    LIMPA: begin
                        if (soma == 5'd0) begin
                            limpa_soma <= 1'b0;
                            estado     <= OCIOSO;
                            ocupado    <= 1'b0;
                        end
                    end
                    default: begin
                        estado  <= OCIOSO;
                        ocupado <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_controle_venda.sv
// Bench for controle_venda: table of directed transactions, randomized
// transactions scored against a price/greedy-change reference, and hand-written
// sequences for power-off, async reset and held-confirm behaviour.
module tb_controle_venda;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       on_off;
    logic [4:0] soma;
    logic       valorultrapassou;
    logic [1:0] produto;
    logic       confirma;
    logic       cancela;
    logic       troco_ack;
    logic       libera_produto;
    logic       troco_valido;
    logic [1:0] troco_moeda;
    logic       limpa_soma;
    logic       saldo_insuf;
    logic       ocupado;

    controle_venda dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .on_off           (on_off),
        .soma             (soma),
        .valorultrapassou (valorultrapassou),
        .produto          (produto),
        .confirma         (confirma),
        .cancela          (cancela),
        .troco_ack        (troco_ack),
        .libera_produto   (libera_produto),
        .troco_valido     (troco_valido),
        .troco_moeda      (troco_moeda),
        .limpa_soma       (limpa_soma),
        .saldo_insuf      (saldo_insuf),
        .ocupado          (ocupado)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Observations of one transaction.
    int         n_lib, n_ins, lib_k, ins_k;
    bit         saw_limpa, timed_out;
    logic [1:0] obs_q[$];
    logic [1:0] exp_q[$];

    // Drive one request from idle and play the dispenser/adder side until the
    // controller is idle again. Samples on the falling edge.
    task automatic run_txn(input logic [4:0] s, input logic [1:0] p,
                           input logic [2:0] act, input int stall, input bit rnd);
        int         clr_cnt;
        int         stall_left;
        bit         prev_hold, prev_ack;
        logic [1:0] prev_coin;
        n_lib = 0; n_ins = 0; lib_k = 0; ins_k = 0;
        saw_limpa = 0; timed_out = 1;
        obs_q.delete();
        clr_cnt = -1; stall_left = stall;
        prev_hold = 0; prev_ack = 0; prev_coin = 2'b00;
        soma = s; produto = p;
        {valorultrapassou, cancela, confirma} = act;
        troco_ack = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clock);
            confirma = 1'b0; cancela = 1'b0; valorultrapassou = 1'b0;
            if (libera_produto) begin n_lib++; lib_k = k; end
            if (saldo_insuf)    begin n_ins++; ins_k = k; end
            if (prev_hold) begin
                check("valid_held", int'(troco_valido), 1);
                check("coin_held", int'(troco_moeda), int'(prev_coin));
            end
            if (prev_ack) check("idle_after_ack", int'(troco_valido), 0);
            prev_hold = 0; prev_ack = 0;
            troco_ack = 1'b0;
            if (troco_valido) begin
                if (stall_left > 0) stall_left--;
                else if (!rnd || $urandom_range(0, 1) == 1) troco_ack = 1'b1;
                if (troco_ack) begin
                    obs_q.push_back(troco_moeda);
                    prev_ack = 1;
                end else begin
                    prev_hold = 1;
                    prev_coin = troco_moeda;
                end
            end else if (rnd) begin
                troco_ack = 1'($urandom_range(0, 1));
            end
            if (limpa_soma) begin
                saw_limpa = 1;
                if (clr_cnt < 0) clr_cnt = rnd ? int'($urandom_range(0, 3)) : 0;
                if (clr_cnt == 0) soma = 5'd0;
                else clr_cnt--;
            end
            if (k >= 3 && !ocupado && !troco_valido && !limpa_soma) begin
                timed_out = 0;
                break;
            end
        end
        troco_ack = 1'b0;
    endtask

    task automatic score(input string tag, input int e_lib, input int e_ins, input bit e_limpa);
        check({tag, "_timeout"}, int'(timed_out), 0);
        check({tag, "_libera_count"}, n_lib, e_lib);
        check({tag, "_insuf_count"}, n_ins, e_ins);
        check({tag, "_limpa_seen"}, int'(saw_limpa), int'(e_limpa));
        check({tag, "_coin_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check($sformatf("%s_coin%0d", tag, i), int'(obs_q[i]), int'(exp_q[i]));
        if (e_lib == 1) check({tag, "_libera_latency"}, lib_k, 3);
        if (e_ins == 1) check({tag, "_insuf_latency"}, ins_k, 2);
    endtask

    // Reference: price lookup, refund/change amount, greedy coin breakdown.
    task automatic model(input logic [4:0] s, input logic [1:0] p, input logic [2:0] act,
                         output int e_lib, output int e_ins, output bit e_limpa);
        int prices[4];
        int r;
        prices = '{4, 6, 8, 10};
        e_lib = 0; e_ins = 0; e_limpa = 0; r = -1;
        exp_q.delete();
        if (act[2] || act[1]) begin
            if (s > 0) r = int'(s);
        end else if (act[0]) begin
            if (int'(s) >= prices[p]) begin
                e_lib = 1;
                r = int'(s) - prices[p];
            end else begin
                e_ins = 1;
            end
        end
        if (r >= 0) begin
            e_limpa = 1;
            while (r > 0) begin
                if (r >= 10)     begin exp_q.push_back(2'b11); r -= 10; end
                else if (r >= 5) begin exp_q.push_back(2'b10); r -= 5;  end
                else if (r >= 2) begin exp_q.push_back(2'b01); r -= 2;  end
                else             begin exp_q.push_back(2'b00); r -= 1;  end
            end
        end
    endtask

    // act = {valorultrapassou, cancela, confirma}; coins packed first coin in [1:0].
    typedef struct {
        logic [4:0] s;
        logic [1:0] p;
        logic [2:0] act;
        int         stall;
        int         lib;
        int         ins;
        bit         limpa;
        int         n;
        logic [7:0] coins;
    } vec_t;

    localparam int NVEC = 15;
    vec_t tbl[NVEC];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int         e_lib, e_ins;
        bit         e_limpa;
        logic [4:0] rs;
        logic [1:0] rp;
        logic [2:0] ra;
        logic [7:0] cw;

        tbl[0]  = '{5'd10, 2'd3, 3'b001, 0, 1, 0, 1'b1, 0, 8'h00};
        tbl[1]  = '{5'd17, 2'd0, 3'b001, 0, 1, 0, 1'b1, 3, 8'h07};
        tbl[2]  = '{5'd5,  2'd2, 3'b001, 0, 0, 1, 1'b0, 0, 8'h00};
        tbl[3]  = '{5'd12, 2'd0, 3'b011, 0, 0, 0, 1'b1, 2, 8'h07};
        tbl[4]  = '{5'd15, 2'd0, 3'b100, 0, 0, 0, 1'b1, 2, 8'h0B};
        tbl[5]  = '{5'd11, 2'd0, 3'b001, 5, 1, 0, 1'b1, 2, 8'h06};
        tbl[6]  = '{5'd31, 2'd1, 3'b001, 0, 1, 0, 1'b1, 3, 8'h2F};
        tbl[7]  = '{5'd0,  2'd0, 3'b010, 0, 0, 0, 1'b0, 0, 8'h00};
        tbl[8]  = '{5'd4,  2'd0, 3'b001, 0, 1, 0, 1'b1, 0, 8'h00};
        tbl[9]  = '{5'd9,  2'd3, 3'b001, 0, 0, 1, 1'b0, 0, 8'h00};
        tbl[10] = '{5'd3,  2'd0, 3'b010, 0, 0, 0, 1'b1, 2, 8'h01};
        tbl[11] = '{5'd31, 2'd2, 3'b100, 2, 0, 0, 1'b1, 4, 8'h3F};
        tbl[12] = '{5'd0,  2'd1, 3'b100, 0, 0, 0, 1'b0, 0, 8'h00};
        tbl[13] = '{5'd0,  2'd0, 3'b011, 0, 0, 0, 1'b0, 0, 8'h00};
        tbl[14] = '{5'd0,  2'd0, 3'b001, 0, 0, 1, 1'b0, 0, 8'h00};

        reset_n = 1'b0; on_off = 1'b1; soma = 5'd0; produto = 2'd0;
        valorultrapassou = 1'b0; confirma = 1'b0; cancela = 1'b0; troco_ack = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_outputs",
              int'({libera_produto, troco_valido, troco_moeda, limpa_soma, saldo_insuf, ocupado}), 0);
        reset_n = 1'b1;
        @(negedge clock);
        check("idle_after_reset", int'(ocupado), 0);

        // Directed table.
        for (int i = 0; i < NVEC; i++) begin
            exp_q.delete();
            cw = tbl[i].coins;
            for (int j = 0; j < tbl[i].n; j++) exp_q.push_back(cw[2*j +: 2]);
            run_txn(tbl[i].s, tbl[i].p, tbl[i].act, tbl[i].stall, 1'b0);
            score($sformatf("vec%0d", i), tbl[i].lib, tbl[i].ins, tbl[i].limpa);
        end

        // Power-off while paying change of 8: first coin is a 5.
        soma = 5'd8; cancela = 1'b1;
        @(negedge clock); cancela = 1'b0;
        @(negedge clock);
        check("abort_coin_valid", int'(troco_valido), 1);
        check("abort_coin_code", int'(troco_moeda), 2);
        on_off = 1'b0;
        @(negedge clock);
        check("abort_outputs",
              int'({libera_produto, troco_valido, troco_moeda, limpa_soma, saldo_insuf, ocupado}), 0);
        on_off = 1'b1; soma = 5'd0;
        @(negedge clock);
        check("abort_stays_idle", int'({troco_valido, ocupado}), 0);

        // Asynchronous reset while in LIBERA.
        soma = 5'd10; produto = 2'd3; confirma = 1'b1;
        @(negedge clock); confirma = 1'b0;
        @(negedge clock);
        check("libera_busy", int'(ocupado), 1);
        reset_n = 1'b0;
        #1;
        check("async_reset_outputs",
              int'({libera_produto, troco_valido, troco_moeda, limpa_soma, saldo_insuf, ocupado}), 0);
        @(negedge clock); reset_n = 1'b1; soma = 5'd0;
        @(negedge clock); @(negedge clock);
        check("post_reset_no_release", int'({libera_produto, ocupado}), 0);

        // Held confirm with insufficient credit: pulse every 2 cycles.
        n_ins = 0; n_lib = 0;
        soma = 5'd5; produto = 2'd2; confirma = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clock);
            if (saldo_insuf) n_ins++;
            if (libera_produto) n_lib++;
            if (k == 6) confirma = 1'b0;
        end
        check("held_insuf_pulses", n_ins, 3);
        check("held_insuf_no_release", n_lib, 0);
        check("held_insuf_idle", int'({ocupado, limpa_soma}), 0);

        // Randomized transactions against the reference.
        for (int t = 0; t < 80; t++) begin
            rs = 5'($urandom_range(0, 31));
            rp = 2'($urandom_range(0, 3));
            ra = 3'($urandom_range(0, 7));
            model(rs, rp, ra, e_lib, e_ins, e_limpa);
            run_txn(rs, rp, ra, int'($urandom_range(0, 3)), 1'b1);
            score($sformatf("rnd%0d", t), e_lib, e_ins, e_limpa);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
